// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA sync generator (640x480@60 defaults).
// The optional VGA_CLKDIV_EN build is handled in vga_sync_gen, not here.
package vga_timing_pkg;

  localparam int COUNT_W   = 11;
  localparam int MAX_TOTAL = 2 ** COUNT_W;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  localparam bit VGA_SYNC_ACTIVE = 1'b0;

  function automatic int axis_total(input int visible, input int fp,
                                    input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  localparam int VGA_H_TOTAL      = axis_total(VGA_H_VISIBLE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int VGA_V_TOTAL      = axis_total(VGA_V_VISIBLE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: modulo counter with enable, wrap strobe, and decode of the
// sync pulse and blank region for the value the counter will hold next.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE     = VGA_H_VISIBLE,
  parameter int FP          = VGA_H_FP,
  parameter int SYNC        = VGA_H_SYNC,
  parameter int BP          = VGA_H_BP,
  parameter bit SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] count_next,
  output logic               wrap,
  output logic               sync_next,
  output logic               blank_next
);

  localparam int TOTAL      = axis_total(VISIBLE, FP, SYNC, BP);
  localparam int SYNC_START = VISIBLE + FP;
  localparam int SYNC_END   = SYNC_START + SYNC - 1;

  localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] VIS_END = COUNT_W'(VISIBLE);
  localparam logic [COUNT_W-1:0] S_START = COUNT_W'(SYNC_START);
  localparam logic [COUNT_W-1:0] S_END   = COUNT_W'(SYNC_END);

  generate
    if (TOTAL > MAX_TOTAL) begin : g_total_too_large
      $error("vga_axis_counter: axis total %0d exceeds counter range %0d", TOTAL, MAX_TOTAL);
    end
  endgenerate

  assign wrap = en && (count == LAST);

  always_comb begin
    count_next = count;
    if (en) begin
      count_next = (count == LAST) ? '0 : count + 1'b1;
    end
  end

  // Decoding the next value lets the parent register outputs aligned with count.
  always_comb begin
    sync_next  = ~SYNC_ACTIVE;
    blank_next = 1'b0;
    if ((count_next >= S_START) && (count_next <= S_END)) begin
      sync_next = SYNC_ACTIVE;
    end
    if (count_next >= VIS_END) begin
      blank_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster timing generator: scan position, blank, syncs, frame_tick.
// Define VGA_CLKDIV_EN to advance on every second clk (50 MHz board clock).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = VGA_H_VISIBLE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_VISIBLE   = VGA_V_VISIBLE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter bit SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COUNT_W-1:0] hcount,
  output logic [COUNT_W-1:0] vcount,
  output logic               blank,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_tick
);

  localparam logic [COUNT_W-1:0] V_TICK_LINE = COUNT_W'(V_VISIBLE);

  logic               adv;
  logic               h_wrap;
  logic               v_wrap_unused;
  logic [COUNT_W-1:0] h_next;
  logic [COUNT_W-1:0] v_next;
  logic               h_sync_next;
  logic               v_sync_next;
  logic               h_blank_next;
  logic               v_blank_next;

`ifdef VGA_CLKDIV_EN
  logic phase;

  // Pixel enable at half the clk rate; the first advance lands on the second edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

  assign adv = phase;
`else
  assign adv = 1'b1;
`endif

  vga_axis_counter #(
    .VISIBLE     (H_VISIBLE),
    .FP          (H_FP),
    .SYNC        (H_SYNC),
    .BP          (H_BP),
    .SYNC_ACTIVE (SYNC_ACTIVE)
  ) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .en         (adv),
    .count      (hcount),
    .count_next (h_next),
    .wrap       (h_wrap),
    .sync_next  (h_sync_next),
    .blank_next (h_blank_next)
  );

  vga_axis_counter #(
    .VISIBLE     (V_VISIBLE),
    .FP          (V_FP),
    .SYNC        (V_SYNC),
    .BP          (V_BP),
    .SYNC_ACTIVE (SYNC_ACTIVE)
  ) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .en         (h_wrap),
    .count      (vcount),
    .count_next (v_next),
    .wrap       (v_wrap_unused),
    .sync_next  (v_sync_next),
    .blank_next (v_blank_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank      <= 1'b0;
      hsync      <= ~SYNC_ACTIVE;
      vsync      <= ~SYNC_ACTIVE;
      frame_tick <= 1'b0;
    end else if (adv) begin
      blank      <= h_blank_next | v_blank_next;
      hsync      <= h_sync_next;
      vsync      <= v_sync_next;
      frame_tick <= (h_next == '0) && (v_next == V_TICK_LINE);
    end
  end

endmodule
